// File: rtl/esp8266_pkg.sv
// Shared definitions for the ESP8266 UART transmit path: arbiter state
// encoding, requester indices and the character-time derivation that the
// controller timing also relies on.
package esp8266_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DRAIN = 2'd2
    } arb_state_e;

    localparam int REQ_CFG = 0;
    localparam int REQ_APP = 1;

    localparam int PACE_W = 15;

    // One UART character is 10 bit times (start, 8 data, stop).
    function automatic int calc_byte_cycles(input int clk_fre, input int baud_rate);
        return (clk_fre / baud_rate) * 10;
    endfunction

endpackage

// File: rtl/esp8266_tx_arb_if.sv
// Byte handshake bundle between the two requesters, the arbiter and the
// uart_tx byte port. slave = arbiter side, master = requester/uart side.
interface esp8266_tx_arb_if;

    logic       req0;
    logic       req1;
    logic [7:0] data0;
    logic [7:0] data1;
    logic       flag0;
    logic       flag1;
    logic       last0;
    logic       last1;
    logic       gnt0;
    logic       gnt1;
    logic       rdy0;
    logic       rdy1;
    logic [7:0] tx_data;
    logic       tx_flag;

    modport slave (
        input  req0, req1, data0, data1, flag0, flag1, last0, last1,
        output gnt0, gnt1, rdy0, rdy1, tx_data, tx_flag
    );

    modport master (
        output req0, req1, data0, data1, flag0, flag1, last0, last1,
        input  gnt0, gnt1, rdy0, rdy1, tx_data, tx_flag
    );

endinterface

// File: rtl/esp8266_tx_arb_tx_pacer.sv
// Loadable down-counter that saturates at zero; idle is high while the
// count is zero. Used to space bytes one UART character time apart.
module tx_pacer
    import esp8266_pkg::*;
#(
    parameter int W = PACE_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         idle
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Load on request, otherwise count down and hold at zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign idle = (count_q == '0);

endmodule

// File: rtl/esp8266_tx_arb.sv
// Frame-level round-robin arbiter sharing one uart_tx byte port between the
// config sequencer (REQ_CFG) and the payload sender (REQ_APP). Bytes are
// paced to one character time; grants last until the frame has drained.
// Optional macro TX_ARB_TIMEOUT_EN adds an idle-grant timeout and the
// timeout_pulse output.
module esp8266_tx_arb
    import esp8266_pkg::*;
#(
    parameter int CLK_FRE     = 50_000_000,
    parameter int BAUD_RATE   = 115200,
    parameter int BYTE_CYCLES = calc_byte_cycles(CLK_FRE, BAUD_RATE)
`ifdef TX_ARB_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 50_000_000
`endif
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst_n,
    esp8266_tx_arb_if.slave        bus,
    input  logic                   err_clr,
    output logic                   busy,
    output logic                   drop_err
`ifdef TX_ARB_TIMEOUT_EN
    , output logic                 timeout_pulse
`endif
);

    localparam logic [PACE_W-1:0] PACE_LOAD = PACE_W'(BYTE_CYCLES - 1);

    arb_state_e state_q, state_d;
    logic [1:0] gnt_q, gnt_d;
    logic       ptr_q, ptr_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       tx_flag_q, tx_flag_d;
    logic       drop_q, drop_d;

    logic [1:0] req_v, flag_v, last_v, rdy_v, acc_v;
    logic       drop_set;
    logic       pace_idle;
    logic       timeout_hit;

    assign req_v  = {bus.req1, bus.req0};
    assign flag_v = {bus.flag1, bus.flag0};
    assign last_v = {bus.last1, bus.last0};

    assign rdy_v    = gnt_q & {2{(state_q == GRANT) && pace_idle}};
    assign acc_v    = flag_v & rdy_v;
    assign drop_set = |(flag_v & ~(gnt_q & rdy_v));

    tx_pacer #(.W(PACE_W)) u_pacer (
        .clk      (sys_clk),
        .rst_n    (sys_rst_n),
        .load     (|acc_v),
        .load_val (PACE_LOAD),
        .idle     (pace_idle)
    );

`ifdef TX_ARB_TIMEOUT_EN
    logic [31:0] idle_cnt_q, idle_cnt_d;

    // Count GRANT cycles without an accepted byte; fire once at the limit.
    always_comb begin
        idle_cnt_d  = '0;
        timeout_hit = 1'b0;
        if (state_q == GRANT && acc_v == 2'b00) begin
            if (idle_cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
                timeout_hit = 1'b1;
            end else begin
                idle_cnt_d = idle_cnt_q + 32'd1;
            end
        end
    end

    // Idle-grant counter register.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            idle_cnt_q <= '0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
        end
    end

    assign timeout_pulse = timeout_hit;
`else
    assign timeout_hit = 1'b0;
`endif

    // Arbitration FSM plus byte forwarding and sticky drop flag.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        ptr_d     = ptr_q;
        tx_flag_d = |acc_v;
        tx_data_d = tx_data_q;
        drop_d    = drop_q;

        if (acc_v[REQ_APP]) begin
            tx_data_d = bus.data1;
        end else if (acc_v[REQ_CFG]) begin
            tx_data_d = bus.data0;
        end

        if (drop_set) begin
            drop_d = 1'b1;
        end else if (err_clr) begin
            drop_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (req_v == 2'b11) begin
                    gnt_d   = ptr_q ? 2'b10 : 2'b01;
                    ptr_d   = ~ptr_q;
                    state_d = GRANT;
                end else if (req_v != 2'b00) begin
                    gnt_d   = req_v;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if ((|(acc_v & last_v)) || !(|(req_v & gnt_q)) || timeout_hit) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pace_idle) begin
                    state_d = IDLE;
                    gnt_d   = 2'b00;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 2'b00;
            end
        endcase
    end

    // State, grant, pointer and output registers.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= IDLE;
            gnt_q     <= 2'b00;
            ptr_q     <= 1'b0;
            tx_data_q <= 8'h00;
            tx_flag_q <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            ptr_q     <= ptr_d;
            tx_data_q <= tx_data_d;
            tx_flag_q <= tx_flag_d;
            drop_q    <= drop_d;
        end
    end

    assign bus.gnt0    = gnt_q[REQ_CFG];
    assign bus.gnt1    = gnt_q[REQ_APP];
    assign bus.rdy0    = rdy_v[REQ_CFG];
    assign bus.rdy1    = rdy_v[REQ_APP];
    assign bus.tx_data = tx_data_q;
    assign bus.tx_flag = tx_flag_q;
    assign busy        = (state_q != IDLE);
    assign drop_err    = drop_q;

endmodule

// File: tb/tb_esp8266_tx_arb.sv
// Bench for esp8266_tx_arb: directed frames on both requesters, bytes pushed
// to an expected queue when strobed, popped by a monitor on tx_flag.
`timescale 1ns/1ps
module tb_esp8266_tx_arb;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic err_clr = 1'b0;
    logic busy;
    logic drop_err;
`ifdef TX_ARB_TIMEOUT_EN
    logic timeout_pulse;
`endif

    esp8266_tx_arb_if bus ();

    esp8266_tx_arb #(
        .CLK_FRE   (50_000_000),
        .BAUD_RATE (115200)
`ifdef TX_ARB_TIMEOUT_EN
        , .TIMEOUT_CYCLES (1000)
`endif
    ) dut (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .bus       (bus),
        .err_clr   (err_clr),
        .busy      (busy),
        .drop_err  (drop_err)
`ifdef TX_ARB_TIMEOUT_EN
        , .timeout_pulse (timeout_pulse)
`endif
    );

    localparam int BC = 4340;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] expQ[$];
    int txTimes[$];
    int total = 0;
    int bad = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Monitor: every byte the DUT emits must be the next expected one.
    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput("gnt_exclusive", {31'd0, bus.gnt0 & bus.gnt1}, 32'd0);
            if (bus.tx_flag) begin
                txTimes.push_back(cyc);
                if (expQ.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL tx_unexpected: got byte %02h expected no byte (cycle %0d)", bus.tx_data, cyc);
                end else begin
                    checkOutput("tx_data", {24'd0, bus.tx_data}, {24'd0, expQ.pop_front()});
                end
            end
        end
    end

    // Strobe one byte on the first cycle the requester's rdy is high.
    task automatic applyStimulus(input int idx, input logic [7:0] d, input logic l,
                                 input logic dropReq, output int accCyc);
        int n;
        n = 0;
        accCyc = -1;
        @(negedge clk);
        while (!(idx == 0 ? bus.rdy0 : bus.rdy1) && n < 6000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 6000) begin
            total++;
            bad++;
            $display("[TB] FAIL rdy%0d_wait: rdy stayed 0 for %0d cycles, expected 1", idx, n);
            return;
        end
        expQ.push_back(d);
        if (idx == 0) begin
            bus.data0 = d; bus.last0 = l; bus.flag0 = 1'b1;
            if (dropReq) bus.req0 = 1'b0;
        end else begin
            bus.data1 = d; bus.last1 = l; bus.flag1 = 1'b1;
            if (dropReq) bus.req1 = 1'b0;
        end
        accCyc = cyc + 1;
        @(posedge clk);
        #1;
        bus.flag0 = 1'b0; bus.flag1 = 1'b0;
        bus.last0 = 1'b0; bus.last1 = 1'b0;
    endtask

    task automatic waitCyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation still running at cycle %0d, expected finish", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int a1, a2, a3, a, b, c, d, e;
        bus.req0 = 0; bus.req1 = 0; bus.data0 = 0; bus.data1 = 0;
        bus.flag0 = 0; bus.flag1 = 0; bus.last0 = 0; bus.last1 = 0;

        // Reset values
        repeat (2) @(negedge clk);
        checkOutput("rst_gnt0", {31'd0, bus.gnt0}, 0);
        checkOutput("rst_gnt1", {31'd0, bus.gnt1}, 0);
        checkOutput("rst_rdy0", {31'd0, bus.rdy0}, 0);
        checkOutput("rst_tx_flag", {31'd0, bus.tx_flag}, 0);
        checkOutput("rst_tx_data", {24'd0, bus.tx_data}, 0);
        checkOutput("rst_busy", {31'd0, busy}, 0);
        checkOutput("rst_drop_err", {31'd0, drop_err}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("idle_busy", {31'd0, busy}, 0);

        // Test 1: single requester, three paced bytes
        bus.req0 = 1'b1;
        @(negedge clk);
        checkOutput("t1_gnt0", {31'd0, bus.gnt0}, 1);
        checkOutput("t1_rdy0", {31'd0, bus.rdy0}, 1);
        checkOutput("t1_busy", {31'd0, busy}, 1);
        applyStimulus(0, 8'h2B, 1'b0, 1'b0, a1);
        applyStimulus(0, 8'h2B, 1'b0, 1'b0, a2);
        applyStimulus(0, 8'h2B, 1'b1, 1'b0, a3);
        bus.req0 = 1'b0;
        checkOutput("t1_accept_space1", a2 - a1, BC);
        checkOutput("t1_accept_space2", a3 - a2, BC);
        waitCyc(a3 + BC - 1);
        checkOutput("t1_drain_gnt0", {31'd0, bus.gnt0}, 1);
        checkOutput("t1_drain_rdy0", {31'd0, bus.rdy0}, 0);
        waitCyc(a3 + BC);
        checkOutput("t1_end_gnt0", {31'd0, bus.gnt0}, 0);
        checkOutput("t1_end_busy", {31'd0, busy}, 0);
        checkOutput("t1_tx_count", txTimes.size(), 3);
        if (txTimes.size() == 3) begin
            checkOutput("t1_tx_space1", txTimes[1] - txTimes[0], BC);
            checkOutput("t1_tx_space2", txTimes[2] - txTimes[1], BC);
        end

        // Test 2/3: simultaneous requests, drops and error clearing
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        @(negedge clk);
        checkOutput("t2_first_gnt0", {31'd0, bus.gnt0}, 1);
        checkOutput("t2_first_gnt1", {31'd0, bus.gnt1}, 0);
        bus.data1 = 8'h55; bus.flag1 = 1'b1;
        @(negedge clk); bus.flag1 = 1'b0;
        checkOutput("t3_drop_set", {31'd0, drop_err}, 1);
        checkOutput("t3_drop_no_tx", {31'd0, bus.tx_flag}, 0);
        err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        checkOutput("t3_clear", {31'd0, drop_err}, 0);
        err_clr = 1'b1; bus.flag1 = 1'b1;
        @(negedge clk); err_clr = 1'b0; bus.flag1 = 1'b0;
        checkOutput("t3_set_wins", {31'd0, drop_err}, 1);
        err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        checkOutput("t3_clear2", {31'd0, drop_err}, 0);

        applyStimulus(0, 8'h41, 1'b1, 1'b0, a);
        @(negedge clk); bus.data0 = 8'h99; bus.flag0 = 1'b1;
        @(negedge clk); bus.flag0 = 1'b0;
        checkOutput("t3_drop_not_rdy", {31'd0, drop_err}, 1);
        err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        checkOutput("t3_clear3", {31'd0, drop_err}, 0);
        waitCyc(a + BC);
        checkOutput("t2_gap_gnt0", {31'd0, bus.gnt0}, 0);
        checkOutput("t2_gap_gnt1", {31'd0, bus.gnt1}, 0);
        checkOutput("t2_gap_busy", {31'd0, busy}, 0);
        waitCyc(a + BC + 1);
        checkOutput("t2_second_gnt1", {31'd0, bus.gnt1}, 1);
        checkOutput("t2_second_gnt0", {31'd0, bus.gnt0}, 0);
        applyStimulus(1, 8'h42, 1'b1, 1'b0, b);
        waitCyc(b + BC + 1);
        checkOutput("t2_rr_gnt0", {31'd0, bus.gnt0}, 1);
        checkOutput("t2_rr_gnt1", {31'd0, bus.gnt1}, 0);

        // Test 4: abort after one byte, waiting requester takes over
        applyStimulus(0, 8'h43, 1'b0, 1'b0, c);
        bus.req0 = 1'b0;
        waitCyc(c + BC - 1);
        checkOutput("t4_drain_gnt0", {31'd0, bus.gnt0}, 1);
        checkOutput("t4_drain_rdy0", {31'd0, bus.rdy0}, 0);
        checkOutput("t4_drain_busy", {31'd0, busy}, 1);
        waitCyc(c + BC + 1);
        checkOutput("t4_handover_gnt0", {31'd0, bus.gnt0}, 0);
        checkOutput("t4_handover_gnt1", {31'd0, bus.gnt1}, 1);

        // Test 5: last byte with req falling, then reset during DRAIN
        applyStimulus(1, 8'h44, 1'b1, 1'b1, d);
        @(negedge clk);
        checkOutput("t5_pre_rst_tx_flag", {31'd0, bus.tx_flag}, 1);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("t5_rst_gnt1", {31'd0, bus.gnt1}, 0);
        checkOutput("t5_rst_tx_flag", {31'd0, bus.tx_flag}, 0);
        checkOutput("t5_rst_tx_data", {24'd0, bus.tx_data}, 0);
        checkOutput("t5_rst_busy", {31'd0, busy}, 0);
        bus.req0 = 1'b1;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        checkOutput("t5_fresh_gnt0", {31'd0, bus.gnt0}, 1);
        checkOutput("t5_fresh_gnt1", {31'd0, bus.gnt1}, 0);
        e = cyc;

`ifdef TX_ARB_TIMEOUT_EN
        // Test 6: grant revoked after an idle grant period
        bus.req0 = 1'b0; bus.req1 = 1'b1;
        waitCyc(e + 3);
        checkOutput("t6_gnt1", {31'd0, bus.gnt1}, 1);
        bus.req0 = 1'b1;
        waitCyc(e + 3 + 998);
        checkOutput("t6_no_early_pulse", {31'd0, timeout_pulse}, 0);
        waitCyc(e + 3 + 999);
        checkOutput("t6_pulse", {31'd0, timeout_pulse}, 1);
        bus.req1 = 1'b0;
        waitCyc(e + 3 + 1000);
        checkOutput("t6_pulse_single", {31'd0, timeout_pulse}, 0);
        waitCyc(e + 3 + 1001);
        checkOutput("t6_revoked_gnt1", {31'd0, bus.gnt1}, 0);
        waitCyc(e + 3 + 1002);
        checkOutput("t6_next_gnt0", {31'd0, bus.gnt0}, 1);
`endif

        repeat (2) @(negedge clk);
        checkOutput("sb_empty", expQ.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
